// File: rtl/mano_cpu_io.sv
// -----------------------------------------------------------------------------
// mano_cpu_io
//   Parametrised Mano accumulator CPU with the I/O and interrupt subsystem.
//   Instructions and data live in a single-port synchronous SRAM with one cycle
//   of read latency. A byte-wide peripheral connects through an input flag
//   (FGI) and an output flag (FGO) using valid/ready handshakes.
//
//   Optional feature: define MANO_INTR_EN to build the interrupt cycle
//   (R flip-flop, return address saved to M[0], jump to address 1).
//   Without it R is tied low and ION/IOF only update IEN.
//
// Parameters
//   DWIDTH   data/instruction width (>= 16); decode uses bits [15:0]
//   AWIDTH   address width (<= 12); address field is IR[AWIDTH-1:0]
//   IO_WIDTH width of INPR/OUTR (<= DWIDTH)
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   mem_rdata            SRAM read data, valid one cycle after mem_addr
//   mem_wdata, mem_we    SRAM write data and one-cycle write strobe
//   mem_addr             SRAM address (AR)
//   ac                   accumulator, debug view
//   inp_data/valid/ready input byte handshake (ready = ~FGI)
//   out_data/valid/ready output byte handshake (data = OUTR)
//   halted               high after HLT
// -----------------------------------------------------------------------------
module mano_cpu_io #(
  parameter int DWIDTH   = 16,
  parameter int AWIDTH   = 12,
  parameter int IO_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DWIDTH-1:0]   mem_rdata,
  output logic [DWIDTH-1:0]   mem_wdata,
  output logic                mem_we,
  output logic [AWIDTH-1:0]   mem_addr,
  output logic [DWIDTH-1:0]   ac,
  input  logic [IO_WIDTH-1:0] inp_data,
  input  logic                inp_valid,
  output logic                inp_ready,
  output logic [IO_WIDTH-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                halted
);

  typedef enum logic [3:0] {
    T0, T1, T2, T3, T4, T5, T6, T7, T8, T9
  } phase_t;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_RIO = 3'd7;  // register-reference or I/O

  phase_t              r_sc, w_sc_next;
  logic [DWIDTH-1:0]   r_ac, r_dr, r_mem_wdata;
  logic [15:0]         r_ir;
  logic [AWIDTH-1:0]   r_pc, r_ar;
  logic                r_e, r_i;
  logic [2:0]          r_d;
  logic [IO_WIDTH-1:0] r_inpr, r_outr;
  logic                r_fgi, r_fgo, r_ien;
  logic                r_halted, r_mem_we, r_out_valid;
  logic                w_r;            // interrupt cycle in progress / pending

  logic [DWIDTH-1:0]   w_rr_ac;
  logic                w_rr_e, w_rr_skip;

  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_ar;
  assign ac        = r_ac;
  assign inp_ready = ~r_fgi;
  assign out_data  = r_outr;
  assign out_valid = r_out_valid;
  assign halted    = r_halted;

  // ---------------------------------------------------------------------------
  // Sequence counter: state register and next-phase logic.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of block ordering.
    if (!reset_n) r_sc <= T0;
    else          r_sc <= w_sc_next;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // it unassigned would infer a latch.
    w_sc_next = r_sc;
    if (w_r) begin
      // Interrupt cycle RT0..RT2 reuses the first three phases.
      case (r_sc)
        T0:      w_sc_next = T1;
        T1:      w_sc_next = T2;
        default: w_sc_next = T0;
      endcase
    end else if (!r_halted) begin
      case (r_sc)
        T0: w_sc_next = T1;
        T1: w_sc_next = T2;
        T2: w_sc_next = T3;
        T3: w_sc_next = T4;
        T4: w_sc_next = (r_d == OP_RIO) ? T0 : T5;
        T5: w_sc_next = T6;
        T6: w_sc_next = T7;
        T7: w_sc_next = (r_d == OP_STA || r_d == OP_BUN) ? T0 : T8;
        T8: w_sc_next = (r_d == OP_ISZ) ? T9 : T0;
        default: w_sc_next = T0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Register-reference micro-ops. Set bits are applied in listed order
  // (CLA, CLE, CMA, CME, CIR, CIL, INC); skip tests look at the values
  // the instruction started with.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: blocking assignments here build a chain where each step sees the
    // previous step's result within the same cycle.
    w_rr_ac   = r_ac;
    w_rr_e    = r_e;
    w_rr_skip = 1'b0;
    if (r_ir[11]) w_rr_ac = '0;
    if (r_ir[10]) w_rr_e  = 1'b0;
    if (r_ir[9])  w_rr_ac = ~w_rr_ac;
    if (r_ir[8])  w_rr_e  = ~w_rr_e;
    if (r_ir[7])  {w_rr_ac, w_rr_e} = {w_rr_e, w_rr_ac};  // rotate right via E
    if (r_ir[6])  {w_rr_e, w_rr_ac} = {w_rr_ac, w_rr_e};  // rotate left via E
    if (r_ir[5])  w_rr_ac = w_rr_ac + DWIDTH'(1);
    if ((r_ir[4] && !r_ac[DWIDTH-1]) ||
        (r_ir[3] &&  r_ac[DWIDTH-1]) ||
        (r_ir[2] &&  r_ac == '0)     ||
        (r_ir[1] && !r_e))
      w_rr_skip = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Interrupt request flip-flop.
  // ---------------------------------------------------------------------------
`ifdef MANO_INTR_EN
  logic r_r;
  logic w_instr_end, w_irq_req;

  // An instruction finishes when SC is about to return to T0 from a later
  // phase; while halted SC sits at T0, so requests are polled there instead.
  assign w_instr_end = !r_halted && (r_sc != T0) && (w_sc_next == T0);
  assign w_irq_req   = r_ien && (r_fgi || r_fgo);
  assign w_r         = r_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_r <= 1'b0;
    end else if (r_r) begin
      if (r_sc == T2) r_r <= 1'b0;
    end else if (w_irq_req && (w_instr_end || (r_halted && r_sc == T0))) begin
      r_r <= 1'b1;
    end
  end
`else
  logic w_unused_ien;
  assign w_r          = 1'b0;
  assign w_unused_ien = r_ien;  // IEN has no consumer without the interrupt cycle
`endif

  // ---------------------------------------------------------------------------
  // Datapath, flags and handshakes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ac        <= '0;
      r_dr        <= '0;
      r_ir        <= '0;
      r_pc        <= '0;
      r_ar        <= '0;
      r_e         <= 1'b0;
      r_i         <= 1'b0;
      r_d         <= '0;
      r_inpr      <= '0;
      r_outr      <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_out_valid <= 1'b0;
      r_fgi       <= 1'b0;
      r_fgo       <= 1'b1;
      r_ien       <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;

      // Handshakes run every cycle, halted or not. Later assignments in this
      // block (INP clearing FGI, OUT loading OUTR) take priority.
      if (inp_valid && !r_fgi) begin
        r_inpr <= inp_data;
        r_fgi  <= 1'b1;
      end
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
        r_fgo       <= 1'b1;
      end

      if (w_r) begin
        case (r_sc)
          T0: begin
            r_ar        <= '0;
            r_mem_wdata <= DWIDTH'(r_pc);
          end
          T1: begin
            r_mem_we <= 1'b1;
            r_pc     <= AWIDTH'(1);
          end
          default: begin
            r_ien    <= 1'b0;
            r_halted <= 1'b0;
          end
        endcase
      end else if (!r_halted) begin
        case (r_sc)
          T0: r_ar <= r_pc;
          T1: r_pc <= r_pc + AWIDTH'(1);
          T2: r_ir <= mem_rdata[15:0];
          T3: begin
            r_i  <= r_ir[15];
            r_ar <= r_ir[AWIDTH-1:0];
            r_d  <= r_ir[14:12];
          end
          T4: begin
            if (r_d == OP_RIO && !r_i) begin
              r_ac <= w_rr_ac;
              r_e  <= w_rr_e;
              if (w_rr_skip) r_pc <= r_pc + AWIDTH'(1);
              if (r_ir[0])   r_halted <= 1'b1;
            end else if (r_d == OP_RIO) begin
              if (r_ir[11]) begin
                r_ac[IO_WIDTH-1:0] <= r_inpr;
                r_fgi              <= 1'b0;
              end
              if (r_ir[10]) begin
                r_outr      <= r_ac[IO_WIDTH-1:0];
                r_out_valid <= 1'b1;
                r_fgo       <= 1'b0;
              end
              if ((r_ir[9] && r_fgi) || (r_ir[8] && r_fgo))
                r_pc <= r_pc + AWIDTH'(1);
              if (r_ir[7]) r_ien <= 1'b1;
              if (r_ir[6]) r_ien <= 1'b0;
            end
          end
          T5: if (r_i) r_ar <= mem_rdata[AWIDTH-1:0];
          T7: begin
            case (r_d)
              OP_AND, OP_ADD, OP_LDA, OP_ISZ: r_dr <= mem_rdata;
              OP_STA: begin
                r_mem_wdata <= r_ac;
                r_mem_we    <= 1'b1;
              end
              OP_BUN: r_pc <= r_ar;
              OP_BSA: begin
                // AR is bumped one phase later than the write is launched:
                // the registered strobe lands during T8 and must still see
                // the original effective address on mem_addr.
                r_mem_wdata <= DWIDTH'(r_pc);
                r_mem_we    <= 1'b1;
              end
              default: ;
            endcase
          end
          T8: begin
            case (r_d)
              OP_AND: r_ac <= r_ac & r_dr;
              OP_ADD: {r_e, r_ac} <= {1'b0, r_ac} + {1'b0, r_dr};
              OP_LDA: r_ac <= r_dr;
              OP_BSA: begin
                r_ar <= r_ar + AWIDTH'(1);
                r_pc <= r_ar + AWIDTH'(1);
              end
              OP_ISZ: r_dr <= r_dr + DWIDTH'(1);
              default: ;
            endcase
          end
          T9: begin
            r_mem_wdata <= r_dr;
            r_mem_we    <= 1'b1;
            if (r_dr == '0) r_pc <= r_pc + AWIDTH'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mano_cpu_io.sv
// -----------------------------------------------------------------------------
// tb_mano_cpu_io
//   Self-checking bench for mano_cpu_io with default parameters. Holds a
//   behavioural 4K x 16 synchronous SRAM, runs a table of short programs with
//   hand-computed accumulator results, then hand-written sequences for fetch
//   timing, indirect addressing, ISZ write-back, I/O handshakes, the interrupt
//   cycle (MANO_INTR_EN) and reset in the middle of a store.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mano_cpu_io;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] mem_rdata;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [15:0] ac;
  logic [7:0]  inp_data;
  logic        inp_valid;
  logic        inp_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        halted;

  mano_cpu_io dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .ac        (ac),
    .inp_data  (inp_data),
    .inp_valid (inp_valid),
    .inp_ready (inp_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM; the bench preloads it through its own write port.
  logic [15:0] mem [4096];
  logic        tb_clr = 1'b0;
  logic        tb_we  = 1'b0;
  logic [11:0] tb_addr = '0;
  logic [15:0] tb_data = '0;

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
    end else if (tb_we) begin
      mem[tb_addr] <= tb_data;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hold the CPU in reset and clear memory; called on a negedge.
  task automatic begin_prog();
    reset_n   = 1'b0;
    inp_valid = 1'b0;
    out_ready = 1'b0;
    inp_data  = '0;
    @(negedge clk);
    tb_clr = 1'b1;
    @(negedge clk);
    tb_clr = 1'b0;
  endtask

  task automatic poke(input int a, input logic [15:0] d);
    tb_we   = 1'b1;
    tb_addr = 12'(a);
    tb_data = d;
    @(negedge clk);
    tb_we   = 1'b0;
  endtask

  // Counts posedges after reset release until halted, bounded by budget.
  task automatic wait_halted(input string name, input int budget, output int cycles);
    cycles = 0;
    while (!halted && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    check(name, halted, 1);
  endtask

  typedef struct {
    string       name;
    logic [15:0] i1;
    logic [15:0] i2;
    logic [15:0] op8;
    logic [15:0] op9;
    logic [15:0] exp_ac;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int cyc;
    logic [11:0] addr0;
    int moves, pulses, pulse_cyc;
    logic [11:0] pulse_addr, addr_at17, addr_at11;
    logic [15:0] pulse_data;
    logic [11:0] exp_addr [9];

    // Program: LDA 8; i1; i2; INC; HLT.  i2 = 7000 is the zero-pattern no-op.
    vecs[0]  = '{"add",      16'h1009, 16'h7000, 16'h1234, 16'h0101, 16'h1336};
    vecs[1]  = '{"and",      16'h0009, 16'h7000, 16'hF0F0, 16'h3C3C, 16'h3031};
    vecs[2]  = '{"cma",      16'h7200, 16'h7000, 16'h00FF, 16'h0000, 16'hFF01};
    vecs[3]  = '{"cla",      16'h7800, 16'h7000, 16'h1234, 16'h0000, 16'h0001};
    vecs[4]  = '{"inc_wrap", 16'h7020, 16'h7000, 16'hFFFF, 16'h0000, 16'h0001};
    vecs[5]  = '{"cil",      16'h7040, 16'h7000, 16'h8001, 16'h0000, 16'h0003};
    vecs[6]  = '{"cir",      16'h7080, 16'h7000, 16'h0003, 16'h0000, 16'h0002};
    vecs[7]  = '{"cme_cir",  16'h7180, 16'h7000, 16'h0002, 16'h0000, 16'h8002};
    vecs[8]  = '{"add_carry",16'h1009, 16'h7040, 16'h8000, 16'h8000, 16'h0002};
    vecs[9]  = '{"sza_skip", 16'h7004, 16'h7200, 16'h0000, 16'h0000, 16'h0001};
    vecs[10] = '{"sna_skip", 16'h7008, 16'h7200, 16'h8000, 16'h0000, 16'h8001};
    vecs[11] = '{"spa_noskp",16'h7010, 16'h7200, 16'h8000, 16'h0000, 16'h8000};
    vecs[12] = '{"sze_skip", 16'h7002, 16'h7200, 16'h1234, 16'h0000, 16'h1235};

    // ---- Reset values --------------------------------------------------------
    reset_n   = 1'b0;
    inp_valid = 1'b0;
    out_ready = 1'b0;
    inp_data  = '0;
    #1;
    check("rst_ac",        ac,        0);
    check("rst_mem_we",    mem_we,    0);
    check("rst_mem_addr",  mem_addr,  0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_inp_ready", inp_ready, 1);
    check("rst_halted",    halted,    0);
    @(negedge clk);

    // ---- Table-driven short programs ----------------------------------------
    for (int v = 0; v < 13; v++) begin
      begin_prog();
      poke(0, 16'h2008);
      poke(1, vecs[v].i1);
      poke(2, vecs[v].i2);
      poke(3, 16'h7020);
      poke(4, 16'h7001);
      poke(8, vecs[v].op8);
      poke(9, vecs[v].op9);
      reset_n = 1'b1;
      wait_halted({vecs[v].name, "_halt"}, 200, cyc);
      check({vecs[v].name, "_ac"}, ac, vecs[v].exp_ac);
    end

    // ---- LDA, ADD with carry, HLT; latency and freeze ------------------------
    begin_prog();
    poke(0, 16'h2005);
    poke(1, 16'h1006);
    poke(2, 16'h7001);
    poke(5, 16'hFFFF);
    poke(6, 16'h0001);
    reset_n = 1'b1;
    wait_halted("seq1_halt", 100, cyc);
    check("seq1_ac", ac, 16'h0000);
    check("seq1_cycles", cyc, 23);   // 9 (LDA) + 9 (ADD) + 5 (HLT)
    addr0 = mem_addr;
    moves = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (mem_addr !== addr0 || mem_we !== 1'b0 || halted !== 1'b1) moves++;
    end
    check("seq1_frozen", moves, 0);

    // ---- Indirect LDA: address sequence 000, 004, 010 -----------------------
    begin_prog();
    poke(0, 16'hA004);
    poke(1, 16'h7001);
    poke(4, 16'h0010);
    poke(16'h10, 16'h1234);
    exp_addr = '{12'h000, 12'h000, 12'h000, 12'h004, 12'h004,
                 12'h010, 12'h010, 12'h010, 12'h010};
    reset_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check($sformatf("ind_addr_c%0d", k + 1), mem_addr, exp_addr[k]);
      if (k == 7) check("ind_ac_before_t8", ac, 16'h0000);
    end
    check("ind_ac_after_t8", ac, 16'h1234);

    // ---- ISZ write-back and skip --------------------------------------------
    begin_prog();
    poke(0, 16'h6008);
    poke(1, 16'h7001);
    poke(2, 16'h7001);
    poke(8, 16'hFFFF);
    reset_n    = 1'b1;
    pulses     = 0;
    pulse_cyc  = 0;
    pulse_addr = '0;
    pulse_data = '1;
    addr_at11  = '0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (mem_we) begin
        pulses++;
        pulse_cyc  = k;
        pulse_addr = mem_addr;
        pulse_data = mem_wdata;
      end
      if (k == 11) addr_at11 = mem_addr;
    end
    check("isz_pulses",     pulses,     1);
    check("isz_pulse_cyc",  pulse_cyc,  10);
    check("isz_pulse_addr", pulse_addr, 12'h008);
    check("isz_pulse_data", pulse_data, 16'h0000);
    check("isz_next_pc",    addr_at11,  12'h002);
    check("isz_mem8",       mem[8],     16'h0000);

    // ---- Input then output handshake ----------------------------------------
    begin_prog();
    poke(0, 16'hF800);
    poke(1, 16'hF400);
    poke(2, 16'h7001);
    inp_data  = 8'h5A;
    inp_valid = 1'b1;
    reset_n   = 1'b1;
    @(negedge clk);
    check("io_fgi_set", inp_ready, 0);
    inp_valid = 1'b0;
    inp_data  = 8'h00;
    wait_halted("io_halt", 100, cyc);
    check("io_ac",        ac,        16'h005A);
    check("io_fgi_clr",   inp_ready, 1);
    check("io_out_valid", out_valid, 1);
    check("io_out_data",  out_data,  8'h5A);
    moves = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== 8'h5A) moves++;
    end
    check("io_out_held", moves, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("io_out_taken", out_valid, 0);
    check("io_out_stable", out_data, 8'h5A);

    // ---- ION then BUN loop: interrupt cycle ---------------------------------
    begin_prog();
    poke(0, 16'hF080);
    poke(1, 16'h4001);
    inp_data  = 8'hA5;
    inp_valid = 1'b1;
    reset_n   = 1'b1;
    pulses     = 0;
    pulse_cyc  = 0;
    pulse_addr = '1;
    pulse_data = '1;
    addr_at17  = '0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (mem_we) begin
        pulses++;
        if (pulses == 1) begin
          pulse_cyc  = k;
          pulse_addr = mem_addr;
          pulse_data = mem_wdata;
        end
      end
      if (k == 17) addr_at17 = mem_addr;
    end
    inp_valid = 1'b0;
    check("intr_resume_addr", addr_at17, 12'h001);
`ifdef MANO_INTR_EN
    check("intr_pulses",     pulses,     1);
    check("intr_pulse_cyc",  pulse_cyc,  15);
    check("intr_pulse_addr", pulse_addr, 12'h000);
    check("intr_pulse_data", pulse_data, 16'h0001);
    check("intr_mem0",       mem[0],     16'h0001);
`else
    check("nointr_pulses", pulses, 0);
    check("nointr_mem0",   mem[0], 16'hF080);
`endif

    // ---- Reset during T7 of STA ---------------------------------------------
    begin_prog();
    poke(0, 16'h2005);
    poke(1, 16'h3006);
    poke(2, 16'h7001);
    poke(5, 16'hABCD);
    reset_n = 1'b1;
    for (int k = 0; k < 16; k++) @(negedge clk);
    check("sta_ac_loaded", ac, 16'hABCD);
    reset_n = 1'b0;   // STA is in T7 now
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (mem_we) pulses++;
    end
    check("rst2_no_write",  pulses,    0);
    check("rst2_mem6",      mem[6],    16'h0000);
    check("rst2_ac",        ac,        0);
    check("rst2_mem_addr",  mem_addr,  0);
    check("rst2_mem_wdata", mem_wdata, 0);
    check("rst2_out_valid", out_valid, 0);
    check("rst2_out_data",  out_data,  0);
    check("rst2_inp_ready", inp_ready, 1);
    check("rst2_halted",    halted,    0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
